// File: rtl/pp_shift_accum.sv
// pp_shift_accum
//   Partial-product shift-and-accumulate unit for the sequential multiplier
//   datapath. Each accepted beat is zero-extended to OUT_W, shifted left by
//   shift_sel*SLICE_W and summed into a full-width accumulator. The finished
//   sum is presented over a valid/ready handshake.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset_a    in   1      asynchronous reset, active high
//   clr        in   1      synchronous abort/clear, beats all handshakes
//   in_valid   in   1      input beat valid
//   in_ready   out  1      unit can accept a beat (IDLE or ACC)
//   inp        in   IN_W   partial product
//   shift_sel  in   SEL_W  shift position (>= N_SLICES means no shift)
//   in_first   in   1      beat starts a new sum
//   in_last    in   1      beat ends the sum
//   out_valid  out  1      result valid (DONE)
//   out_ready  in   1      consumer accepts result
//   result     out  OUT_W  accumulator, modulo 2^OUT_W
//   overflow   out  1      sticky carry out of OUT_W for the current sum
//   beat_count out  CNT_W  beats in current sum, saturating
module pp_shift_accum #(
  parameter  int IN_W     = 8,
  parameter  int SLICE_W  = 4,
  parameter  int N_SLICES = 3,
  parameter  int CNT_W    = 4,
  localparam int SEL_W    = ($clog2(N_SLICES + 1) > 1) ? $clog2(N_SLICES + 1) : 1,
  localparam int OUT_W    = IN_W + SLICE_W * (N_SLICES - 1)
) (
  input  logic             clk,
  input  logic             reset_a,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  inp,
  input  logic [SEL_W-1:0] shift_sel,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic             overflow,
  output logic [CNT_W-1:0] beat_count
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [OUT_W-1:0] shifted;
  logic [OUT_W:0]   sum;

  // Only legal slice positions shift; anything out of range (and slice 0)
  // leaves the beat unshifted.
  always_comb begin
    shifted = OUT_W'(inp);
    for (int s = 1; s < N_SLICES; s++) begin
      if (shift_sel == SEL_W'(s)) shifted = OUT_W'(inp) << (s * SLICE_W);
    end
  end

  // Extra top bit carries out of OUT_W into the sticky overflow flag.
  assign sum = {1'b0, acc_q} + {1'b0, shifted};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, ACC: begin
          if (in_valid) begin
            // From IDLE every beat opens a sum, in_first or not.
            if (state_q == IDLE || in_first) begin
              acc_d = shifted;
              ovf_d = 1'b0;
              cnt_d = CNT_W'(1);
            end else begin
              acc_d = sum[OUT_W-1:0];
              ovf_d = ovf_q | sum[OUT_W];
              cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            end
            state_d = in_last ? DONE : ACC;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready   = (state_q != DONE);
  assign out_valid  = (state_q == DONE);
  assign result     = acc_q;
  assign overflow   = ovf_q;
  assign beat_count = cnt_q;

endmodule
